// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-light sequencer.
// A trigger lights NUM_LIGHTS lamps, one per prescaler tick. All lamps are
// then held on for a hold period, after which they go dark. The block then
// counts clock cycles until the driver reacts.
// A reaction while lamps are still lighting or holding is a jump start.
//
// Build option: F1_RANDOM_HOLD_EN
//   Defined:   the hold length is taken from a 7-bit LFSR (1..127 ticks).
//   Undefined: the hold length is HOLD_TICKS.
//
// dbg_state_o exposes the FSM state for checkers:
//   0 = IDLE, 1 = LIGHT, 2 = HOLD, 3 = OUT.
module f1_start_seq #(
  parameter int NUM_LIGHTS = 8,
  parameter int WIDTH      = 16,
  parameter int RT_W       = 16,
  parameter int HOLD_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trigger,
  input  logic                  react,
  input  logic [WIDTH-1:0]      N,
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  busy,
  output logic [RT_W-1:0]       react_time,
  output logic                  react_valid,
  output logic                  jump_start,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LIGHT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_LIGHTS-1:0] data_q, data_d;
  logic [WIDTH-1:0]      presc_q, presc_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic [RT_W-1:0]       rt_cnt_q, rt_cnt_d;
  logic [RT_W-1:0]       react_time_q, react_time_d;
  logic                  valid_q, valid_d;
  logic                  js_q, js_d;
  logic                  tick;
  logic [NUM_LIGHTS-1:0] shifted;
  logic [WIDTH-1:0]      hold_load;

`ifdef F1_RANDOM_HOLD_EN
  logic [6:0] lfsr_q, lfsr_d;

  // x^7 + x^6 + 1 Fibonacci LFSR, stepping on every enabled cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  // LFSR register, seeded with a non-zero value so it never locks up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 7'h01;
    else     lfsr_q <= lfsr_d;
  end

  assign hold_load = WIDTH'(lfsr_q);
`else
  assign hold_load = WIDTH'(HOLD_TICKS);
`endif

  // A tick fires when the prescaler has counted down to zero on an enabled cycle.
  assign tick    = en && (presc_q == '0);
  assign shifted = {data_q[NUM_LIGHTS-2:0], 1'b1};

  // Next-state logic. A reaction takes priority over a tick in the same cycle.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    rt_cnt_d     = rt_cnt_q;
    react_time_d = react_time_q;
    valid_d      = 1'b0;
    js_d         = 1'b0;
    if (en) begin
      presc_d = (presc_q == '0) ? N : presc_q - WIDTH'(1);
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d = ST_LIGHT;
            data_d  = NUM_LIGHTS'(1);
            presc_d = N;
          end
        end
        ST_LIGHT: begin
          if (react) begin
            js_d    = 1'b1;
            data_d  = '0;
            state_d = ST_IDLE;
          end else if (tick) begin
            data_d = shifted;
            if (&shifted) begin
              state_d = ST_HOLD;
              hold_d  = hold_load;
              presc_d = N;
            end
          end
        end
        ST_HOLD: begin
          if (react) begin
            js_d    = 1'b1;
            data_d  = '0;
            state_d = ST_IDLE;
          end else if (tick) begin
            // A zero hold count is treated like one, so the sequencer cannot stall here.
            if (hold_q <= WIDTH'(1)) begin
              state_d  = ST_OUT;
              data_d   = '0;
              rt_cnt_d = '0;
            end else begin
              hold_d = hold_q - WIDTH'(1);
            end
          end
        end
        default: begin
          if (react) begin
            react_time_d = rt_cnt_q;
            valid_d      = 1'b1;
            state_d      = ST_IDLE;
          end else if (rt_cnt_q != '1) begin
            rt_cnt_d = rt_cnt_q + RT_W'(1);
          end
        end
      endcase
    end
  end

  // State registers. Reset clears everything at once, including the pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
      rt_cnt_q     <= '0;
      react_time_q <= '0;
      valid_q      <= 1'b0;
      js_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      rt_cnt_q     <= rt_cnt_d;
      react_time_q <= react_time_d;
      valid_q      <= valid_d;
      js_q         <= js_d;
    end
  end

  assign data_out    = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign react_time  = react_time_q;
  assign react_valid = valid_q;
  assign jump_start  = js_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Directed bench for f1_start_seq.
// A second instance with a 4-bit reaction counter shares all inputs with the
// main instance and is used to check saturation.
// Build option F1_RANDOM_HOLD_EN switches the hold-length checks.
module tb_f1_start_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        trigger;
  logic        react;
  logic [15:0] N;

  always #5 clk = ~clk;

  logic [7:0]  data_out, data_out_s;
  logic        busy, busy_s;
  logic [15:0] react_time;
  logic [3:0]  react_time_s;
  logic        react_valid, react_valid_s;
  logic        jump_start, jump_start_s;
  logic [1:0]  dbg_state, dbg_state_s;

  f1_start_seq #(.NUM_LIGHTS(8), .WIDTH(16), .RT_W(16), .HOLD_TICKS(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react), .N(N),
    .data_out(data_out), .busy(busy), .react_time(react_time),
    .react_valid(react_valid), .jump_start(jump_start), .dbg_state_o(dbg_state)
  );

  f1_start_seq #(.NUM_LIGHTS(8), .WIDTH(16), .RT_W(4), .HOLD_TICKS(3)) u_sat (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react), .N(N),
    .data_out(data_out_s), .busy(busy_s), .react_time(react_time_s),
    .react_valid(react_valid_s), .jump_start(jump_start_s), .dbg_state_o(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: observed %0h, nothing expected", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, data_out %0h", tag, data_out);
  endtask

  // ---------------- driver tasks ----------------
  // Every task starts and ends at a falling edge.
  task automatic wait_data(input logic [7:0] v, input int max_cyc);
    int cyc;
    cyc = 0;
    while (data_out !== v && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (data_out !== v) timeout_fail("wait_data");
  endtask

  task automatic wait_change(output int cyc);
    logic [7:0] v;
    v   = data_out;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (data_out === v && cyc < 100);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Runs one full sequence with N=0, returns the number of all-on cycles and
  // reacts 5 cycles after the lamps go dark.
  task automatic run_hold(output int len);
    pulse_trigger();
    wait_data(8'hFF, 400);
    len = 0;
    while (data_out === 8'hFF && len < 300) begin
      @(negedge clk);
      len++;
    end
    check("out_dark", data_out, 8'h00);
    repeat (5) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check("hold_rt", react_time, 5);
    check("hold_rt_sat", react_time_s, 5);
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c, total, len, mn, mx;
    rst = 1'b1; en = 1'b1; trigger = 1'b0; react = 1'b0; N = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rt", react_time, 0);
    check("rst_valid", react_valid, 0);
    check("rst_js", jump_start, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequence with N=0: one new lamp per cycle, then three all-on cycles, then dark.
    for (int i = 1; i <= 8; i++) exp_q.push_back((32'd1 << i) - 32'd1);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'h00);
    trigger = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      trigger = 1'b0;
      sb_check("lamp_seq", data_out);
      check("busy_seq", busy, 1);
    end
    check("out_state", dbg_state, 3);

    // The reaction counter reads 0 in the first dark cycle, so it reads 37 after 37 more cycles.
    exp_q.push_back(37);
    repeat (37) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check("react_valid", react_valid, 1);
    sb_check("react_time", react_time);
    check("sat_time", react_time_s, 15);
    check("busy_after_react", busy, 0);
    check("js_on_react", jump_start, 0);
    @(negedge clk);
    check("valid_pulse", react_valid, 0);

    // Jump start while three lamps are on.
    pulse_trigger();
    check("js_first", data_out, 8'h01);
    wait_data(8'h07, 20);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check("js_pulse", jump_start, 1);
    check("js_data", data_out, 0);
    check("js_busy", busy, 0);
    check("js_rt_kept", react_time, 37);
    check("js_no_valid", react_valid, 0);
    @(negedge clk);
    check("js_one_cycle", jump_start, 0);
    pulse_trigger();
    check("restart", data_out, 8'h01);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    @(negedge clk);

    // Prescaler N=4: five cycles per lamp. An enable gap of 10 cycles stretches one step to 15.
    N = 16'd4;
    pulse_trigger();
    check("presc_first", data_out, 8'h01);
    wait_change(c);
    check("presc_int1", c, 5);
    check("presc_lamp2", data_out, 8'h03);
    total = 2;
    repeat (2) @(negedge clk);
    en = 1'b0;
    react = 1'b1;
    repeat (10) @(negedge clk);
    check("en_freeze_data", data_out, 8'h03);
    check("en_react_ignored", jump_start, 0);
    total += 10;
    en = 1'b1;
    react = 1'b0;
    wait_change(c);
    total += c;
    check("presc_stretch", total, 15);
    check("presc_lamp3", data_out, 8'h07);
    wait_change(c);
    check("presc_int3", c, 5);
    check("presc_lamp4", data_out, 8'h0F);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    check("presc_js", jump_start, 1);
    N = 16'd0;
    @(negedge clk);

    // Hold length.
`ifdef F1_RANDOM_HOLD_EN
    mn = 1000;
    mx = 0;
    for (int r = 0; r < 20; r++) begin
      run_hold(len);
      check("hold_range", (len >= 1 && len <= 127) ? 1 : 0, 1);
      if (len < mn) mn = len;
      if (len > mx) mx = len;
    end
    check("hold_varies", (mn != mx) ? 1 : 0, 1);
`else
    mn = 0;
    mx = 0;
    for (int r = 0; r < 2; r++) begin
      run_hold(len);
      check("hold_fixed", len, 3);
    end
`endif

    // Reset in the middle of the hold clears the outputs before the next clock edge.
    pulse_trigger();
    wait_data(8'hFF, 400);
    @(negedge clk);
    check("pre_rst_state", dbg_state, 2);
    check("pre_rst_rt", react_time, 5);
    #2 rst = 1'b1;
    #1;
    check("async_data", data_out, 0);
    check("async_busy", busy, 0);
    check("async_rt", react_time, 0);
    check("async_state", dbg_state, 0);
    check("async_js", jump_start, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", react_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/f1_start_seq.md
Name: f1_start_seq

Overview:
Parametrised next-generation F1 start-light sequencer with an integrated tick prescaler, a trigger input and reaction-time measurement. A trigger lights NUM_LIGHTS lamps one per tick and holds them all on for a hold period. The lamps then go dark and the block counts clock cycles until the driver's react input. Early reactions are reported as jump starts. The block sits between the board I/O (button, LED bar) and the display/logging logic.

Parameters:
NUM_LIGHTS, 8, number of lamps on data_out (2..32)
WIDTH, 16, width of prescaler reload value N
RT_W, 16, width of reaction-time counter
HOLD_TICKS, 3, fixed all-on hold in ticks (1..2^WIDTH-1), used when the optional feature is out

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  global enable; low freezes all internal state
trigger  input  1  start request (level sampled each enabled cycle)
react  input  1  driver reaction (level sampled each enabled cycle)
N  input  WIDTH  prescaler reload; tick period = N+1 enabled cycles
data_out  output  NUM_LIGHTS  lamp drive, bit 0 = first lamp
busy  output  1  high in any state other than IDLE
react_time  output  RT_W  last measured reaction, in clk cycles
react_valid  output  1  one-cycle pulse when react_time updates
jump_start  output  1  one-cycle pulse on react during LIGHT/HOLD

Behaviour:
- Reset (async, rst=1): state=IDLE, data_out=0, busy=0, react_time=0, react_valid=0, jump_start=0, prescaler count=0, hold count=0, LFSR=7'h01.
- en=0: no register changes except react_valid/jump_start, which clear to 0. trigger and react are ignored.
- Prescaler: down-counter.
  - tick=1 when count==0 and en=1, then count reloads N; otherwise it decrements.
  - N=0 gives a tick every enabled cycle.
  - Count reloads N on entry to LIGHT and on entry to HOLD.
- States IDLE, LIGHT, HOLD, OUT; all transitions are registered (one cycle).
- IDLE: data_out=0.
  - trigger=1 -> LIGHT, data_out=1 (lamp 0 on in the next cycle).
  - react is ignored.
- LIGHT: on each tick, data_out <= {data_out[NUM_LIGHTS-2:0],1'b1}.
  - On the tick that makes data_out all ones -> HOLD; hold count loads the hold value.
- HOLD: all lamps on. On each tick the hold count decrements.
  - A tick with hold count==1 -> OUT, data_out=0, reaction counter=0.
- OUT: the reaction counter increments every enabled cycle and saturates at 2^RT_W-1 (no wrap).
  - react=1 -> react_time <= counter value, react_valid pulses, state -> IDLE.
  - Latency: react sampled in the first OUT cycle gives react_time=0.
- Jump start: react=1 in LIGHT or HOLD -> jump_start pulses, data_out=0, state -> IDLE; react_time is unchanged.
- Precedence: react beats tick in the same cycle. trigger while busy is ignored.
- Reset mid-sequence returns to the reset values immediately; no output pulses are produced.
- N changes take effect at the next reload only.

Optional Feature:
Macro F1_RANDOM_HOLD_EN.
- Defined:
  - A 7-bit Fibonacci LFSR (x^7+x^6+1) advances every enabled cycle, never reaching 0.
  - The hold value is the LFSR value captured on the LIGHT->HOLD transition (1..127 ticks).
  - HOLD_TICKS is unused.
- Undefined:
  - No LFSR is present.
  - The hold value is HOLD_TICKS.

Test Plan:
- Reset: assert rst mid-HOLD with NUM_LIGHTS=8 -> data_out=0, busy=0, react_time=0 asynchronously, before the next clk edge.
- Basic sequence: N=0, HOLD_TICKS=3, single-cycle trigger -> data_out 01,03,07,...,FF on successive cycles, FF held 3 cycles, then 00 with busy still 1.
- Prescaler: N=4 -> each new lamp appears exactly 5 cycles after the previous one; en low for 10 cycles mid-LIGHT stretches that interval to 15.
- Reaction: N=0, react asserted 37 cycles after data_out goes 00 -> react_time=37, react_valid high for one cycle, busy=0 on the next cycle.
- Jump start: react during data_out=07 -> jump_start one pulse, data_out=00, react_time keeps its previous value, a new trigger restarts from 01.
- Saturation/random: RT_W=4, no react for 40 cycles -> react_time=15 on react. With F1_RANDOM_HOLD_EN, 20 runs give hold lengths all in 1..127 and not all equal.
